// File: rtl/memory_pkg.sv
// Shared constants for the memory block: region select codes, sub-region offsets,
// STM latch register addresses and per-region depths.
package memory_pkg;

    typedef enum logic [1:0] {
        SEL_CTL = 2'd0,
        SEL_MOD = 2'd1,
        SEL_PWE = 2'd2,
        SEL_STM = 2'd3
    } bram_select_t;

    // ADDR[13:8] sub-regions inside SEL_CTL
    localparam logic [5:0]  CTL_OFFSET       = 6'h00;
    localparam logic [5:0]  PHASE_OFFSET     = 6'h01;
    localparam logic [13:0] STM_SEGMENT_ADDR = 14'h0200;
    localparam logic [13:0] STM_PAGE_ADDR    = 14'h0201;

    localparam int SEGMENTS    = 2;
    localparam int PWE_DEPTH   = 256;
    localparam int PHASE_DEPTH = 256;
    localparam int MOD_DEPTH   = 16384;
    localparam int STM_DEPTH   = 65536;

    // Byte-addressed regions are stored as 16-bit words, two bytes per host write.
    localparam int PWE_WORDS   = PWE_DEPTH / 2;
    localparam int PHASE_WORDS = PHASE_DEPTH / 2;
    localparam int MOD_WORDS   = SEGMENTS * MOD_DEPTH / 2;
    localparam int STM_WORDS   = SEGMENTS * STM_DEPTH;

    function automatic logic [7:0] pick_byte(input logic [15:0] word, input logic hi);
        return hi ? word[15:8] : word[7:0];
    endfunction

endpackage

// File: rtl/memory_sdp_bram.sv
// Simple dual-port RAM: one synchronous write port, one read port with a single
// output register (1-cycle latency, old data on a same-address collision).
module sdp_bram #(
    parameter int WIDTH  = 16,
    parameter int DEPTH  = 256,
    parameter int ADDR_W = $clog2(DEPTH)
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [WIDTH-1:0]  wdata,
    input  logic [ADDR_W-1:0] raddr,
    output logic [WIDTH-1:0]  rdata
);

    logic [WIDTH-1:0] mem [DEPTH];

    // NOTE: the array itself is never reset so it maps onto block RAM; only the
    // read register below is cleared.
    always_ff @(posedge CLK) begin
        if (we) mem[waddr] <= wdata;
    end

    // NOTE: non-blocking assignments make a same-cycle write invisible to this
    // read, which is exactly the read-old-data behaviour consumers rely on.
    always_ff @(posedge CLK) begin
        if (RST) rdata <= '0;
        else     rdata <= mem[raddr];
    end

endmodule

// File: rtl/memory.sv
// Host-writable memory block: decodes the host BRAM bus into controller, phase,
// modulation, PWE and STM regions and serves each consumer through its own read port.
module memory
    import memory_pkg::*;
(
    input  logic        CLK,
    input  logic        RST,
    input  logic        mem_en,
    input  logic        mem_we,
    input  logic [1:0]  mem_bram_select,
    input  logic [13:0] mem_addr,
    input  logic [15:0] mem_data_in,
    output logic [15:0] mem_data_out,
    output logic        cnt_we,
    output logic [7:0]  cnt_addr,
    output logic [15:0] cnt_din,
    input  logic [15:0] cnt_dout,
    input  logic [7:0]  phase_corr_idx,
    output logic [7:0]  phase_corr_phase,
    input  logic        mod_segment,
    input  logic [14:0] mod_idx,
    output logic [7:0]  mod_value,
    input  logic        stm_segment,
    input  logic [15:0] stm_addr,
    output logic [15:0] stm_value,
    input  logic [7:0]  pwe_idx,
    output logic [7:0]  pwe_value
);

    bram_select_t sel;
    logic         host_wr;
    logic         host_rd;
    logic         ctl_region;
    logic         phase_region;
    logic         stm_wr_segment;
    logic [1:0]   stm_wr_page;
    logic         phase_hi;
    logic         pwe_hi;
    logic         mod_hi;
    logic [15:0]  phase_word;
    logic [15:0]  pwe_word;
    logic [15:0]  mod_word;
    logic         unused_mod_idx_msb;

    assign sel          = bram_select_t'(mem_bram_select);
    assign host_wr      = mem_en && mem_we && !RST;
    assign host_rd      = mem_en && !mem_we;
    assign ctl_region   = (sel == SEL_CTL) && (mem_addr[13:8] == CTL_OFFSET);
    assign phase_region = (sel == SEL_CTL) && (mem_addr[13:8] == PHASE_OFFSET);

    // Modulation index wraps at the segment depth, so bit 14 never selects anything.
    assign unused_mod_idx_msb = mod_idx[14];

    assign cnt_we   = host_wr && ctl_region;
    assign cnt_addr = mem_addr[7:0];
    assign cnt_din  = mem_data_in;

    always_ff @(posedge CLK) begin
        if (RST) begin
            stm_wr_segment <= 1'b0;
            stm_wr_page    <= 2'd0;
            mem_data_out   <= '0;
        end else begin
            if (host_wr && sel == SEL_CTL && mem_addr == STM_SEGMENT_ADDR)
                stm_wr_segment <= mem_data_in[0];
            if (host_wr && sel == SEL_CTL && mem_addr == STM_PAGE_ADDR)
                stm_wr_page <= mem_data_in[1:0];
            if (host_rd)
                mem_data_out <= ctl_region ? cnt_dout : '0;
        end
    end

    // Byte-lane selects travel alongside the word read so the byte pick lines up.
    always_ff @(posedge CLK) begin
        if (RST) begin
            phase_hi <= 1'b0;
            pwe_hi   <= 1'b0;
            mod_hi   <= 1'b0;
        end else begin
            phase_hi <= phase_corr_idx[0];
            pwe_hi   <= pwe_idx[0];
            mod_hi   <= mod_idx[0];
        end
    end

    sdp_bram #(.WIDTH(16), .DEPTH(PHASE_WORDS)) u_phase (
        .CLK   (CLK),
        .RST   (RST),
        .we    (host_wr && phase_region),
        .waddr (mem_addr[6:0]),
        .wdata (mem_data_in),
        .raddr (phase_corr_idx[7:1]),
        .rdata (phase_word)
    );

    sdp_bram #(.WIDTH(16), .DEPTH(PWE_WORDS)) u_pwe (
        .CLK   (CLK),
        .RST   (RST),
        .we    (host_wr && sel == SEL_PWE),
        .waddr (mem_addr[6:0]),
        .wdata (mem_data_in),
        .raddr (pwe_idx[7:1]),
        .rdata (pwe_word)
    );

    // Both modulation segments share one array; ADDR[13] is the segment bit.
    sdp_bram #(.WIDTH(16), .DEPTH(MOD_WORDS)) u_mod (
        .CLK   (CLK),
        .RST   (RST),
        .we    (host_wr && sel == SEL_MOD),
        .waddr (mem_addr),
        .wdata (mem_data_in),
        .raddr ({mod_segment, mod_idx[13:1]}),
        .rdata (mod_word)
    );

    sdp_bram #(.WIDTH(16), .DEPTH(STM_WORDS)) u_stm (
        .CLK   (CLK),
        .RST   (RST),
        .we    (host_wr && sel == SEL_STM),
        .waddr ({stm_wr_segment, stm_wr_page, mem_addr}),
        .wdata (mem_data_in),
        .raddr ({stm_segment, stm_addr}),
        .rdata (stm_value)
    );

    assign phase_corr_phase = pick_byte(phase_word, phase_hi);
    assign pwe_value        = pick_byte(pwe_word, pwe_hi);
    assign mod_value        = pick_byte(mod_word, mod_hi);

endmodule

// File: tb/tb_memory.sv
// Scoreboard bench for memory: directed scenarios, a bulk STM load/readback and
// randomized traffic checked against a byte/word array model of every region.
module tb_memory;

    logic        CLK = 1'b0;
    logic        RST = 1'b1;
    logic        mem_en = 1'b0;
    logic        mem_we = 1'b0;
    logic [1:0]  mem_bram_select = 2'd0;
    logic [13:0] mem_addr = '0;
    logic [15:0] mem_data_in = '0;
    logic [15:0] mem_data_out;
    logic        cnt_we;
    logic [7:0]  cnt_addr;
    logic [15:0] cnt_din;
    logic [15:0] cnt_dout;
    logic [7:0]  phase_corr_idx = '0;
    logic [7:0]  phase_corr_phase;
    logic        mod_segment = 1'b0;
    logic [14:0] mod_idx = '0;
    logic [7:0]  mod_value;
    logic        stm_segment = 1'b0;
    logic [15:0] stm_addr = '0;
    logic [15:0] stm_value;
    logic [7:0]  pwe_idx = '0;
    logic [7:0]  pwe_value;

    memory dut (
        .CLK              (CLK),
        .RST              (RST),
        .mem_en           (mem_en),
        .mem_we           (mem_we),
        .mem_bram_select  (mem_bram_select),
        .mem_addr         (mem_addr),
        .mem_data_in      (mem_data_in),
        .mem_data_out     (mem_data_out),
        .cnt_we           (cnt_we),
        .cnt_addr         (cnt_addr),
        .cnt_din          (cnt_din),
        .cnt_dout         (cnt_dout),
        .phase_corr_idx   (phase_corr_idx),
        .phase_corr_phase (phase_corr_phase),
        .mod_segment      (mod_segment),
        .mod_idx          (mod_idx),
        .mod_value        (mod_value),
        .stm_segment      (stm_segment),
        .stm_addr         (stm_addr),
        .stm_value        (stm_value),
        .pwe_idx          (pwe_idx),
        .pwe_value        (pwe_value)
    );

    always #5 CLK = ~CLK;

    // Controller register file stand-in: readback is a fixed function of the address.
    function automatic logic [15:0] ctl_fn(input logic [7:0] a);
        return {~a, a};
    endfunction
    assign cnt_dout = ctl_fn(cnt_addr);

    typedef struct packed {
        bit        en;
        bit        we;
        bit [1:0]  sel;
        bit [13:0] addr;
        bit [15:0] din;
    } host_t;

    typedef struct packed {
        bit        chk_phase;
        bit [7:0]  phase_idx;
        bit        chk_pwe;
        bit [7:0]  pwe_idx;
        bit        chk_mod;
        bit        mod_seg;
        bit [14:0] mod_idx;
        bit        chk_stm;
        bit        stm_seg;
        bit [15:0] stm_addr;
    } rd_t;

    typedef enum {P_HOST, P_PHASE, P_PWE, P_MOD, P_STM} port_e;

    typedef struct {
        int unsigned due;
        port_e       port;
        logic [15:0] value;
    } exp_t;

    exp_t        sb[$];
    exp_t        mon_e;
    int unsigned edges = 0;
    int          vectors = 0;
    int          miscompares = 0;

    // Reference model: plain byte/word arrays indexed exactly as the register map reads.
    bit [7:0]  phase_m [256];
    bit [7:0]  pwe_m   [256];
    bit [7:0]  mod_m   [2][16384];
    bit [15:0] stm_m   [2][65536];
    bit        seg_m  = 1'b0;
    bit [1:0]  page_m = 2'd0;

    localparam int TRANSDUCERS = 249;
    localparam int FRAMES      = 16;

    always @(posedge CLK) edges <= edges + 1;

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h at t=%0t", name, act, exp, $time);
        end
    endtask

    function automatic void push(input port_e p, input logic [15:0] v);
        exp_t e;
        e.due   = edges + 1;
        e.port  = p;
        e.value = v;
        sb.push_back(e);
    endfunction

    always @(negedge CLK) begin
        while (sb.size() != 0 && sb[0].due <= edges) begin
            mon_e = sb.pop_front();
            case (mon_e.port)
                P_HOST:  check("host_data_out", mem_data_out, mon_e.value);
                P_PHASE: check("phase_read", {8'h00, phase_corr_phase}, mon_e.value);
                P_PWE:   check("pwe_read", {8'h00, pwe_value}, mon_e.value);
                P_MOD:   check("mod_read", {8'h00, mod_value}, mon_e.value);
                default: check("stm_read", stm_value, mon_e.value);
            endcase
        end
    end

    task automatic model_write(input host_t h);
        int b;
        case (h.sel)
            2'd0: begin
                if (h.addr[13:8] == 6'd1) begin
                    b = 2 * int'(h.addr[6:0]);
                    phase_m[b]     = h.din[7:0];
                    phase_m[b + 1] = h.din[15:8];
                end
                if (h.addr == 14'h0200) seg_m = h.din[0];
                if (h.addr == 14'h0201) page_m = h.din[1:0];
            end
            2'd1: begin
                b = 2 * int'(h.addr[12:0]);
                mod_m[h.addr[13]][b]     = h.din[7:0];
                mod_m[h.addr[13]][b + 1] = h.din[15:8];
            end
            2'd2: begin
                b = 2 * int'(h.addr[6:0]);
                pwe_m[b]     = h.din[7:0];
                pwe_m[b + 1] = h.din[15:8];
            end
            default: stm_m[seg_m][int'(page_m) * 16384 + int'(h.addr)] = h.din;
        endcase
    endtask

    // One bus cycle: drive, record expectations from the pre-write model, then update it.
    task automatic apply(input host_t h, input rd_t r, input bit rst);
        bit ctl_hit;
        bit fwd;
        @(negedge CLK);
        RST             = rst;
        mem_en          = h.en;
        mem_we          = h.we;
        mem_bram_select = h.sel;
        mem_addr        = h.addr;
        mem_data_in     = h.din;
        phase_corr_idx  = r.phase_idx;
        pwe_idx         = r.pwe_idx;
        mod_segment     = r.mod_seg;
        mod_idx         = r.mod_idx;
        stm_segment     = r.stm_seg;
        stm_addr        = r.stm_addr;
        ctl_hit = (h.sel == 2'd0) && (h.addr[13:8] == 6'd0);
        fwd     = !rst && h.en && h.we && ctl_hit;
        if (r.chk_phase) push(P_PHASE, rst ? 16'h0 : {8'h00, phase_m[r.phase_idx]});
        if (r.chk_pwe)   push(P_PWE,   rst ? 16'h0 : {8'h00, pwe_m[r.pwe_idx]});
        if (r.chk_mod)   push(P_MOD,   rst ? 16'h0 : {8'h00, mod_m[r.mod_seg][int'(r.mod_idx) % 16384]});
        if (r.chk_stm)   push(P_STM,   rst ? 16'h0 : stm_m[r.stm_seg][r.stm_addr]);
        if (rst || (h.en && !h.we))
            push(P_HOST, (rst || !ctl_hit) ? 16'h0 : ctl_fn(h.addr[7:0]));
        #1;
        check("cnt_we", {15'h0, cnt_we}, {15'h0, fwd});
        if (fwd) begin
            check("cnt_addr", {8'h00, cnt_addr}, {8'h00, h.addr[7:0]});
            check("cnt_din", cnt_din, h.din);
        end
        if (rst) begin
            seg_m  = 1'b0;
            page_m = 2'd0;
        end else if (h.en && h.we) begin
            model_write(h);
        end
    endtask

    task automatic wr(input bit [1:0] sel, input bit [13:0] addr, input bit [15:0] din);
        host_t h;
        h = '{en: 1'b1, we: 1'b1, sel: sel, addr: addr, din: din};
        apply(h, '0, 1'b0);
    endtask

    task automatic host_rd(input bit [1:0] sel, input bit [13:0] addr);
        host_t h;
        h = '{en: 1'b1, we: 1'b0, sel: sel, addr: addr, din: 16'h0};
        apply(h, '0, 1'b0);
    endtask

    task automatic rd_stm(input bit seg, input bit [15:0] addr);
        rd_t r;
        r = '0;
        r.chk_stm = 1'b1; r.stm_seg = seg; r.stm_addr = addr;
        apply('0, r, 1'b0);
    endtask

    task automatic rd_mod(input bit seg, input bit [14:0] idx);
        rd_t r;
        r = '0;
        r.chk_mod = 1'b1; r.mod_seg = seg; r.mod_idx = idx;
        apply('0, r, 1'b0);
    endtask

    task automatic rd_bytes(input bit [7:0] pwe, input bit [7:0] phase);
        rd_t r;
        r = '0;
        r.chk_pwe = 1'b1; r.pwe_idx = pwe;
        r.chk_phase = 1'b1; r.phase_idx = phase;
        apply('0, r, 1'b0);
    endtask

    initial begin
        host_t h;
        rd_t   r;

        // Reset: every read port and DATA_OUT must come out of reset as zero.
        r = '1;
        r.phase_idx = 8'h0; r.pwe_idx = 8'h0; r.mod_idx = 15'h0; r.stm_addr = 16'h0;
        apply('0, r, 1'b1);
        apply('0, r, 1'b1);

        // STM segment isolation and same-cycle read-old-data.
        wr(2'd0, 14'h0200, 16'h0001);
        wr(2'd0, 14'h0201, 16'h0000);
        wr(2'd3, 14'd5, 16'h1111);
        wr(2'd0, 14'h0200, 16'h0000);
        wr(2'd3, 14'd5, 16'hAB12);
        rd_stm(1'b0, 16'd5);
        rd_stm(1'b1, 16'd5);
        h = '{en: 1'b1, we: 1'b1, sel: 2'd3, addr: 14'd5, din: 16'hCD34};
        r = '0; r.chk_stm = 1'b1; r.stm_seg = 1'b0; r.stm_addr = 16'd5;
        apply(h, r, 1'b0);
        rd_stm(1'b0, 16'd5);

        // Modulation segments, byte lanes and index wrap.
        wr(2'd1, 14'h0003, 16'h9999);
        wr(2'd1, 14'h2003, 16'h3456);
        rd_mod(1'b1, 15'd6);
        rd_mod(1'b1, 15'd7);
        rd_mod(1'b0, 15'd6);
        rd_mod(1'b1, 15'h4006);

        // STM page latch.
        wr(2'd3, 14'd0, 16'h1234);
        wr(2'd0, 14'h0201, 16'h0002);
        wr(2'd3, 14'd0, 16'h00FF);
        rd_stm(1'b0, 16'h8000);
        rd_stm(1'b0, 16'h0000);
        wr(2'd0, 14'h0201, 16'h0000);

        // PWE and phase tables, including a phase address that wraps onto entry 128.
        wr(2'd2, 14'h0010, 16'h0201);
        wr(2'd0, 14'h0140, 16'h7F80);
        rd_bytes(8'd32, 8'd128);
        rd_bytes(8'd33, 8'd129);
        wr(2'd0, 14'h01C0, 16'h1122);
        rd_bytes(8'd32, 8'd128);

        // Controller forwarding and host readback.
        wr(2'd0, 14'h0042, 16'hBEEF);
        host_rd(2'd0, 14'h0012);
        host_rd(2'd1, 14'h0012);
        host_rd(2'd0, 14'h0140);
        host_rd(2'd3, 14'h0000);

        // Reset after loading: outputs and latches clear, arrays keep their contents.
        wr(2'd0, 14'h0200, 16'h0001);
        wr(2'd0, 14'h0201, 16'h0003);
        host_rd(2'd0, 14'h0033);
        h = '{en: 1'b1, we: 1'b1, sel: 2'd2, addr: 14'h0010, din: 16'hFFFF};
        apply(h, '0, 1'b1);
        h = '{en: 1'b1, we: 1'b1, sel: 2'd0, addr: 14'h0005, din: 16'h5555};
        apply(h, '0, 1'b1);
        rd_bytes(8'd32, 8'd128);
        rd_stm(1'b0, 16'd5);
        rd_mod(1'b1, 15'd7);
        wr(2'd3, 14'd7, 16'h7777);
        rd_stm(1'b0, 16'd7);

        // Bulk gain-STM load: 2 segments x 16 frames x 249 transducers.
        for (int s = 0; s < 2; s++) begin
            wr(2'd0, 14'h0200, 16'(s));
            wr(2'd0, 14'h0201, 16'h0000);
            for (int f = 0; f < FRAMES; f++)
                for (int t = 0; t < TRANSDUCERS; t++)
                    wr(2'd3, 14'(f * TRANSDUCERS + t), 16'($urandom));
        end
        for (int s = 0; s < 2; s++)
            for (int w = 0; w < FRAMES * TRANSDUCERS; w++)
                rd_stm(1'(s), 16'(w));

        // Fill the byte tables and a modulation window so random reads hit known data.
        for (int i = 0; i < 128; i++) begin
            wr(2'd0, {6'h01, 1'b0, 7'(i)}, 16'($urandom));
            wr(2'd2, 14'(i), 16'($urandom));
        end
        for (int s = 0; s < 2; s++)
            for (int w = 0; w < 64; w++)
                wr(2'd1, {1'(s), 13'(w)}, 16'($urandom));

        // Randomized mixed traffic on all ports at once.
        for (int n = 0; n < 1500; n++) begin
            h = '0;
            h.din = 16'($urandom);
            case ($urandom_range(0, 5))
                0: begin h.en = 1; h.we = 1; h.sel = 2'd0; h.addr = {6'h01, 8'($urandom)}; end
                1: begin h.en = 1; h.we = 1; h.sel = 2'd2; h.addr = 14'($urandom); end
                2: begin h.en = 1; h.we = 1; h.sel = 2'd1;
                         h.addr = {1'($urandom), 13'($urandom_range(0, 63))}; end
                3: begin h.en = 1; h.we = 1; h.sel = 2'd3;
                         h.addr = 14'($urandom_range(0, FRAMES * TRANSDUCERS - 1)); end
                4: begin
                    h.en = 1; h.we = 0;
                    if ($urandom_range(0, 1) == 1) begin
                        h.sel = 2'd0; h.addr = {6'h00, 8'($urandom)};
                    end else begin
                        h.sel = 2'($urandom); h.addr = 14'($urandom);
                    end
                end
                default: begin h.en = 0; h.we = 1; h.sel = 2'($urandom); h.addr = 14'($urandom); end
            endcase
            r = '0;
            r.chk_phase = 1; r.phase_idx = 8'($urandom);
            r.chk_pwe   = 1; r.pwe_idx   = 8'($urandom);
            r.chk_mod   = 1; r.mod_seg   = 1'($urandom);
            r.mod_idx   = {1'($urandom), 7'h00, 7'($urandom)};
            r.chk_stm   = 1; r.stm_seg   = 1'($urandom);
            r.stm_addr  = 16'($urandom_range(0, FRAMES * TRANSDUCERS - 1));
            apply(h, r, 1'b0);
        end

        repeat (3) apply('0, '0, 1'b0);
        for (int i = 0; i < 8 && sb.size() != 0; i++) @(negedge CLK);
        check("scoreboard_drain", 16'(sb.size()), 16'h0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
